mon_sopc_boutons_debounce: RTL and testbench

Synchronizer and debouncer for the board push-buttons, placed directly upstream of the button PIO slave in `mon_sopc`. Each raw pad input passes through a 2-flop synchronizer. A per-bit counter then qualifies it, so a level change is accepted only after it has been stable for a programmable number of clocks. The clean, active-high `btn_out` vector drives the PIO `in_port`. Optional one-cycle press/release strobes are available for IRQ or edge-capture logic.

---
 rtl/mon_sopc_boutons_debounce.sv | 123 ++++++++++++
 tb/tb_mon_sopc_boutons_debounce.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/mon_sopc_boutons_debounce.sv
// mon_sopc_boutons_debounce
// Push-button conditioner placed in front of the button PIO of mon_sopc.
// Each raw pad is optionally inverted so that 1 means pressed. It then goes
// through a 2-flop synchronizer and a per-bit stability counter. A new level
// is accepted only after it has held for DEBOUNCE_CYCLES consecutive clocks.
// Optional feature macro: MON_SOPC_BOUTONS_PULSE_EN
//   defined     -> registered one-cycle press/release strobes are built
//   not defined -> press_pulse/release_pulse are tied to 0
module mon_sopc_boutons_debounce #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] btn_out,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse
);

   // The counter only has to reach DEBOUNCE_CYCLES-1, so ceil(log2) bits
   // are enough; keep at least one bit for the smallest legal setting.
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Per-bit qualification state: IDLE while the synchronized input agrees
   // with the accepted level, COUNT while it disagrees.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_COUNT = 1'b1
   } state_t;

   logic [WIDTH-1:0] w_cond;
   logic [WIDTH-1:0] r_sync1;
   logic [WIDTH-1:0] r_sync2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] w_accept;
   logic [CNT_W-1:0] r_cnt     [WIDTH];
   logic [CNT_W-1:0] w_cntNext [WIDTH];
   state_t           w_state   [WIDTH];

   assign w_cond = ACTIVE_LOW ? ~raw_in : raw_in;

   // Two-flop synchronizer bringing the asynchronous pads into clk domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_cond;
         r_sync2 <= r_sync1;
      end
   end

   // Next-state decode per bit: count while the input disagrees with the
   // accepted level, accept on terminal count, clear on any bounce back.
   always_comb begin
      w_accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_cntNext[i] = r_cnt[i];
         w_state[i]   = (r_sync2[i] == r_stable[i]) ? ST_IDLE : ST_COUNT;
         case (w_state[i])
            ST_IDLE: begin
               w_cntNext[i] = '0;
            end
            ST_COUNT: begin
               if (r_cnt[i] == CNT_LAST) begin
                  w_accept[i]  = 1'b1;
                  w_cntNext[i] = '0;
               end else begin
                  w_cntNext[i] = r_cnt[i] + 1'b1;
               end
            end
            default: begin
               w_cntNext[i] = '0;
            end
         endcase
      end
   end

   // Accepted level and counters; an accepted bit takes the synchronized
   // value, so btn_out is a plain register output.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stable <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_stable <= (r_stable & ~w_accept) | (r_sync2 & w_accept);
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cntNext[i];
         end
      end
   end

   assign btn_out = r_stable;

`ifdef MON_SOPC_BOUTONS_PULSE_EN
   logic [WIDTH-1:0] r_press;
   logic [WIDTH-1:0] r_release;

   // Strobes are registered on the same edge that updates the accepted
   // level, so they line up with the first cycle of the new btn_out value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_press   <= '0;
         r_release <= '0;
      end else begin
         r_press   <= w_accept & r_sync2;
         r_release <= w_accept & ~r_sync2;
      end
   end

   assign press_pulse   = r_press;
   assign release_pulse = r_release;
`else
   assign press_pulse   = '0;
   assign release_pulse = '0;
`endif

endmodule

// File: tb/tb_mon_sopc_boutons_debounce.sv
// Self-checking bench for mon_sopc_boutons_debounce (WIDTH=2,
// DEBOUNCE_CYCLES=4, ACTIVE_LOW=1). Stimulus is driven on the falling edge;
// a behavioural model predicts the outputs after the next rising edge and
// queues them; a monitor pops and compares 1 ns after each rising edge.
module tb_mon_sopc_boutons_debounce;

   localparam int W = 2;
   localparam int D = 4;

   typedef struct packed {
      logic [W-1:0] btn;
      logic [W-1:0] press;
      logic [W-1:0] rel;
   } expected_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] raw_in = 2'b11;
   logic [W-1:0] btn_out;
   logic [W-1:0] press_pulse;
   logic [W-1:0] release_pulse;

   int errors = 0;
   int checks = 0;
   int pressSeen = 0;
   int releaseSeen = 0;

   expected_t expQ[$];

   // Behavioural model state
   logic [W-1:0] mS1, mS2, mStable, mPress, mRel;
   int           mRun [W];

   mon_sopc_boutons_debounce #(
      .WIDTH(W),
      .DEBOUNCE_CYCLES(D),
      .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .raw_in(raw_in),
      .btn_out(btn_out),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Model of one rising edge: a level is accepted once the synchronized
   // input has disagreed with the accepted level on D consecutive edges.
   task automatic modelEdge(input logic [W-1:0] raw, input logic rst);
      logic [W-1:0] cond;
      cond = ~raw;
      mPress = '0;
      mRel   = '0;
      if (rst) begin
         mS1 = '0;
         mS2 = '0;
         mStable = '0;
         for (int i = 0; i < W; i++) mRun[i] = 0;
      end else begin
         for (int i = 0; i < W; i++) begin
            if (mS2[i] != mStable[i]) mRun[i] = mRun[i] + 1;
            else mRun[i] = 0;
            if (mRun[i] == D) begin
               mStable[i] = mS2[i];
               mRun[i] = 0;
               if (mS2[i]) mPress[i] = 1'b1;
               else mRel[i] = 1'b1;
            end
         end
         mS2 = mS1;
         mS1 = cond;
      end
   endtask

   // Drive n cycles of the given input/reset and queue predicted outputs.
   task automatic applyStimulus(input logic [W-1:0] raw, input logic rst, input int n);
      expected_t e;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         raw_in = raw;
         reset  = rst;
         modelEdge(raw, rst);
         e.btn = mStable;
`ifdef MON_SOPC_BOUTONS_PULSE_EN
         e.press = mPress;
         e.rel   = mRel;
`else
         e.press = '0;
         e.rel   = '0;
`endif
         expQ.push_back(e);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest queued prediction.
   always @(posedge clk) begin
      expected_t e;
      #1;
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("btn_out", 32'(btn_out), 32'(e.btn));
         checkOutput("press_pulse", 32'(press_pulse), 32'(e.press));
         checkOutput("release_pulse", 32'(release_pulse), 32'(e.rel));
         pressSeen   = pressSeen + int'(press_pulse[0]) + int'(press_pulse[1]);
         releaseSeen = releaseSeen + int'(release_pulse[0]) + int'(release_pulse[1]);
      end
   end

   initial begin
      int pressBefore;
      int expPress;
      for (int i = 0; i < W; i++) mRun[i] = 0;
      mS1 = '0; mS2 = '0; mStable = '0; mPress = '0; mRel = '0;

      // 1: reset with buttons released, then idle
      applyStimulus(2'b11, 1'b1, 3);
      applyStimulus(2'b11, 1'b0, 12);
      @(negedge clk);
      checkOutput("idle_btn", 32'(btn_out), 32'h0);

      // 2: press bit 0, then release it
      applyStimulus(2'b10, 1'b0, 10);
      @(negedge clk);
      checkOutput("press0_btn", 32'(btn_out), 32'h1);
      applyStimulus(2'b11, 1'b0, 10);
      @(negedge clk);
      checkOutput("release0_btn", 32'(btn_out), 32'h0);

      // 3: bounce on bit 1 never qualifies
      pressBefore = pressSeen;
      applyStimulus(2'b01, 1'b0, 3);
      applyStimulus(2'b11, 1'b0, 1);
      applyStimulus(2'b01, 1'b0, 3);
      applyStimulus(2'b11, 1'b0, 8);
      @(negedge clk);
      checkOutput("bounce_btn", 32'(btn_out), 32'h0);
      checkOutput("bounce_nopress", 32'(pressSeen - pressBefore), 32'h0);

      // 4: both buttons pressed together
      pressBefore = pressSeen;
      applyStimulus(2'b00, 1'b0, 10);
      @(negedge clk);
      checkOutput("both_btn", 32'(btn_out), 32'h3);
`ifdef MON_SOPC_BOUTONS_PULSE_EN
      expPress = 2;
`else
      expPress = 0;
`endif
      checkOutput("both_press_count", 32'(pressSeen - pressBefore), 32'(expPress));
      applyStimulus(2'b11, 1'b0, 10);

      // 5: reset pulse while bit 0 is mid-count, then full re-qualification
      applyStimulus(2'b10, 1'b0, 4);
      applyStimulus(2'b10, 1'b1, 1);
      applyStimulus(2'b10, 1'b0, 5);
      @(negedge clk);
      checkOutput("rst_mid_hold", 32'(btn_out), 32'h0);
      applyStimulus(2'b10, 1'b0, 6);
      @(negedge clk);
      checkOutput("rst_requal", 32'(btn_out), 32'h1);

      // Random stimulus with held segments of varying length
      for (int s = 0; s < 40; s++) begin
         applyStimulus(2'($urandom_range(0, 3)), 1'b0, $urandom_range(1, 8));
      end

      // Drain
      @(posedge clk);
      #2;
      checkOutput("queue_empty", 32'(expQ.size()), 32'h0);
      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
